// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, writeback result-select
// encodings and load funct3 codes.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      RESULT_ALU  = 2'b00,
      RESULT_LOAD = 2'b01,
      RESULT_PC4  = 2'b10
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM-stage instruction fields and WB control in,
// register-file write port, forwarding value and instret out.
interface wb_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic             mem_valid;
   logic             mem_reg_write;
   logic [4:0]       mem_rd;
   logic [1:0]       mem_result_src;
   logic [2:0]       mem_funct3;
   logic [XLEN-1:0]  mem_alu_result;
   logic [XLEN-1:0]  mem_load_data;
   logic [XLEN-1:0]  mem_pc_plus4;
   logic             wb_stall;
   logic             wb_flush;

   logic             wb_we;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_wd;
   logic             wb_valid;
   logic             wb_misaligned;
   logic [CNT_W-1:0] instret;

   modport master (
      output mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_funct3,
             mem_alu_result, mem_load_data, mem_pc_plus4, wb_stall, wb_flush,
      input  wb_we, wb_rd, wb_wd, wb_valid, wb_misaligned, instret
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_funct3,
             mem_alu_result, mem_load_data, mem_pc_plus4, wb_stall, wb_flush,
      output wb_we, wb_rd, wb_wd, wb_valid, wb_misaligned, instret
   );
endinterface

// File: rtl/wb_stage_load_extract.sv
// Combinational load alignment: picks the addressed byte/half/word out of the
// raw memory word, sign- or zero-extends it, and flags misaligned/illegal loads.
module load_extract
   import core_pkg::*;
(
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_word,
   output logic [XLEN-1:0] o_data,
   output logic            o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
      return {{(XLEN-8){sgn & b[7]}}, b};
   endfunction

   function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
      return {{(XLEN-16){sgn & h[15]}}, h};
   endfunction

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_data       = '0;
      o_misaligned = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = ext8(w_byte, 1'b1);
         F3_LBU: o_data = ext8(w_byte, 1'b0);
         F3_LH: begin
            o_data       = ext16(w_half, 1'b1);
            o_misaligned = i_off[0];
         end
         F3_LHU: begin
            o_data       = ext16(w_half, 1'b0);
            o_misaligned = i_off[0];
         end
         F3_LW: begin
            o_data       = i_word;
            o_misaligned = |i_off;
         end
         // 011, 110, 111 are not loads in RV32I
         default: o_misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, result select, register
// file write port, and the retired-instruction counter.
module wb_stage
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);

   logic [XLEN-1:0]  w_ld_data;
   logic             w_ld_mis;
   logic             w_is_load;
   logic             w_mis;
   logic             w_we;
   logic             w_retire;
   logic [XLEN-1:0]  w_result;

   logic             r_vld_p1;
   logic             r_we_p1;
   logic             r_mis_p1;
   logic [4:0]       r_rd_p1;
   logic [XLEN-1:0]  r_wd_p1;
   logic [CNT_W-1:0] r_instret;

   load_extract u_load_extract (
      .i_funct3     (bus.mem_funct3),
      .i_off        (bus.mem_alu_result[1:0]),
      .i_word       (bus.mem_load_data),
      .o_data       (w_ld_data),
      .o_misaligned (w_ld_mis)
   );

   always_comb begin
      w_is_load = (bus.mem_result_src == RESULT_LOAD);
      w_mis     = bus.mem_valid & w_is_load & w_ld_mis;
      w_result  = bus.mem_alu_result;
      if (w_is_load)
         w_result = w_ld_data;
      else if (bus.mem_result_src == RESULT_PC4)
         w_result = bus.mem_pc_plus4;
      if (w_mis)
         w_result = '0;
      w_we     = bus.mem_valid & bus.mem_reg_write & (bus.mem_rd != 5'd0) & ~w_mis;
      // The instruction currently in WB retires unless it is being held
      w_retire = r_vld_p1 & ~r_mis_p1 & ~bus.wb_stall;
   end

   // ---- MEM -> WB register (p1) ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld_p1  <= 1'b0;
         r_we_p1   <= 1'b0;
         r_mis_p1  <= 1'b0;
         r_rd_p1   <= 5'd0;
         r_wd_p1   <= '0;
         r_instret <= '0;
      end else begin
         if (w_retire)
            r_instret <= r_instret + CNT_W'(1);
         if (bus.wb_flush) begin
            r_vld_p1 <= 1'b0;
            r_we_p1  <= 1'b0;
            r_mis_p1 <= 1'b0;
         end else if (!bus.wb_stall) begin
            r_vld_p1 <= bus.mem_valid;
            r_we_p1  <= w_we;
            r_mis_p1 <= w_mis;
            r_rd_p1  <= bus.mem_rd;
            r_wd_p1  <= w_result;
         end
      end
   end

   assign bus.wb_valid      = r_vld_p1;
   assign bus.wb_we         = r_we_p1;
   assign bus.wb_misaligned = r_mis_p1;
   assign bus.wb_rd         = r_rd_p1;
   assign bus.wb_wd         = r_wd_p1;
   assign bus.instret       = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus
// hand-written reset, stall, flush and counter-wrap sequences.
module tb_wb_stage;

   localparam logic [31:0] W = 32'h80F1_7F02;

   typedef struct {
      logic        vld;
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] pc4;
      logic        e_vld;
      logic        e_we;
      logic        e_mis;
      logic        chkd;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [63:0] m_cnt = 64'd0;
   logic        m_vld = 1'b0;
   logic        m_mis = 1'b0;

   vec_t tbl [15];

   wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();
   wb_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

   wb_stage #(.XLEN(32), .CNT_W(64)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   wb_stage #(.XLEN(32), .CNT_W(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic vld, input logic rw, input logic [4:0] rd,
                               input logic [1:0] src, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] ld,
                               input logic [31:0] pc4, input logic e_vld,
                               input logic e_we, input logic e_mis, input logic chkd,
                               input logic [4:0] e_rd, input logic [31:0] e_wd);
      vec_t v;
      v.vld = vld; v.rw = rw; v.rd = rd; v.src = src; v.f3 = f3;
      v.alu = alu; v.ld = ld; v.pc4 = pc4;
      v.e_vld = e_vld; v.e_we = e_we; v.e_mis = e_mis; v.chkd = chkd;
      v.e_rd = e_rd; v.e_wd = e_wd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [31:0] pc4);
      bus.mem_valid      = vld;
      bus.mem_reg_write  = rw;
      bus.mem_rd         = rd;
      bus.mem_result_src = src;
      bus.mem_funct3     = f3;
      bus.mem_alu_result = alu;
      bus.mem_load_data  = ld;
      bus.mem_pc_plus4   = pc4;
   endtask

   // One clock; tracks the expected instret from the retire rule
   task automatic tick(input logic nv, input logic nm);
      @(posedge clk);
      if (!rst) begin
         m_cnt = 64'd0; m_vld = 1'b0; m_mis = 1'b0;
      end else begin
         if (m_vld && !m_mis && !bus.wb_stall) m_cnt = m_cnt + 64'd1;
         if (bus.wb_flush) begin
            m_vld = 1'b0; m_mis = 1'b0;
         end else if (!bus.wb_stall) begin
            m_vld = nv; m_mis = nm;
         end
      end
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_valid"}, 64'(bus.wb_valid), 64'd0);
      chk({nm, "_we"},    64'(bus.wb_we), 64'd0);
      chk({nm, "_mis"},   64'(bus.wb_misaligned), 64'd0);
      chk({nm, "_rd"},    64'(bus.wb_rd), 64'd0);
      chk({nm, "_wd"},    64'(bus.wb_wd), 64'd0);
      chk({nm, "_cnt"},   bus.instret, 64'd0);
   endtask

   initial begin
      tbl[0]  = mk(1,1,5'd3,2'b01,3'b000,32'h1001,W,0, 1,1,0,1,5'd3,32'h0000_007F);
      tbl[1]  = mk(1,1,5'd4,2'b01,3'b000,32'h1002,W,0, 1,1,0,1,5'd4,32'hFFFF_FFF1);
      tbl[2]  = mk(1,1,5'd5,2'b01,3'b100,32'h1003,W,0, 1,1,0,1,5'd5,32'h0000_0080);
      tbl[3]  = mk(1,1,5'd6,2'b01,3'b001,32'h1002,W,0, 1,1,0,1,5'd6,32'hFFFF_80F1);
      tbl[4]  = mk(1,1,5'd8,2'b01,3'b101,32'h1000,W,0, 1,1,0,1,5'd8,32'h0000_7F02);
      tbl[5]  = mk(1,1,5'd9,2'b01,3'b010,32'h1000,W,0, 1,1,0,1,5'd9,32'h80F1_7F02);
      tbl[6]  = mk(1,1,5'd7,2'b01,3'b010,32'h1002,W,0, 1,0,1,1,5'd7,32'h0);
      tbl[7]  = mk(1,1,5'd7,2'b01,3'b001,32'h1003,W,0, 1,0,1,1,5'd7,32'h0);
      tbl[8]  = mk(1,1,5'd7,2'b01,3'b011,32'h1000,W,0, 1,0,1,1,5'd7,32'h0);
      tbl[9]  = mk(1,1,5'd0,2'b00,3'b000,32'hABCD,W,0, 1,0,0,1,5'd0,32'hABCD);
      tbl[10] = mk(1,1,5'd1,2'b10,3'b000,32'h0999,W,32'h104, 1,1,0,1,5'd1,32'h104);
      tbl[11] = mk(1,1,5'd9,2'b11,3'b000,32'h0055,W,0, 1,1,0,1,5'd9,32'h55);
      tbl[12] = mk(1,0,5'd0,2'b00,3'b010,32'h0202,W,0, 1,0,0,1,5'd0,32'h202);
      tbl[13] = mk(0,1,5'd4,2'b00,3'b000,32'h0077,W,0, 0,0,0,0,5'd0,32'h0);
      tbl[14] = mk(1,1,5'd2,2'b01,3'b000,32'h2000,32'h0000_0080,0, 1,1,0,1,5'd2,32'hFFFF_FF80);

      bus.wb_stall = 1'b0;
      bus.wb_flush = 1'b0;
      bus2.mem_valid = 1'b0;      bus2.mem_reg_write = 1'b0;
      bus2.mem_rd = 5'd0;         bus2.mem_result_src = 2'b00;
      bus2.mem_funct3 = 3'b000;   bus2.mem_alu_result = 32'h0;
      bus2.mem_load_data = 32'h0; bus2.mem_pc_plus4 = 32'h0;
      bus2.wb_stall = 1'b0;       bus2.wb_flush = 1'b0;

      // Reset held with a valid instruction on the inputs
      rst = 1'b0;
      drive(1,1,5'd5,2'b00,3'b000,32'h1234,32'h0,32'h0);
      tick(1,0);
      tick(1,0);
      chk_all_zero("reset");

      rst = 1'b1;
      tick(1,0);
      chk("first_we", 64'(bus.wb_we), 64'd1);
      chk("first_rd", 64'(bus.wb_rd), 64'd5);
      chk("first_wd", 64'(bus.wb_wd), 64'h1234);
      chk("first_cnt", bus.instret, 64'd0);
      drive(0,0,5'd0,2'b00,3'b000,32'h0,32'h0,32'h0);
      tick(0,0);
      chk("first_cnt_next", bus.instret, 64'd1);

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].vld, tbl[i].rw, tbl[i].rd, tbl[i].src, tbl[i].f3,
               tbl[i].alu, tbl[i].ld, tbl[i].pc4);
         tick(tbl[i].e_vld, tbl[i].e_mis);
         chk($sformatf("row%0d_valid", i), 64'(bus.wb_valid), 64'(tbl[i].e_vld));
         chk($sformatf("row%0d_we", i),    64'(bus.wb_we), 64'(tbl[i].e_we));
         chk($sformatf("row%0d_mis", i),   64'(bus.wb_misaligned), 64'(tbl[i].e_mis));
         if (tbl[i].chkd) begin
            chk($sformatf("row%0d_rd", i), 64'(bus.wb_rd), 64'(tbl[i].e_rd));
            chk($sformatf("row%0d_wd", i), 64'(bus.wb_wd), 64'(tbl[i].e_wd));
         end
         chk($sformatf("row%0d_cnt", i), bus.instret, m_cnt);
      end
      chk("table_cnt_total", bus.instret, 64'd11);

      // Stall three cycles while the MEM inputs change underneath
      drive(1,1,5'd10,2'b00,3'b000,32'h42,32'h0,32'h0);
      tick(1,0);
      chk("pre_stall_cnt", bus.instret, 64'd12);
      bus.wb_stall = 1'b1;
      drive(1,1,5'd11,2'b00,3'b000,32'h99,32'h0,32'h0);
      for (int k = 0; k < 3; k++) begin
         tick(1,0);
         chk($sformatf("stall%0d_rd", k),  64'(bus.wb_rd), 64'd10);
         chk($sformatf("stall%0d_wd", k),  64'(bus.wb_wd), 64'h42);
         chk($sformatf("stall%0d_we", k),  64'(bus.wb_we), 64'd1);
         chk($sformatf("stall%0d_cnt", k), bus.instret, 64'd12);
      end
      bus.wb_stall = 1'b0;
      drive(0,0,5'd0,2'b00,3'b000,32'h0,32'h0,32'h0);
      tick(0,0);
      chk("post_stall_cnt", bus.instret, 64'd13);

      // Flush wins over stall
      drive(1,1,5'd12,2'b00,3'b000,32'h33,32'h0,32'h0);
      tick(1,0);
      chk("pre_flush_valid", 64'(bus.wb_valid), 64'd1);
      bus.wb_stall = 1'b1;
      bus.wb_flush = 1'b1;
      tick(1,0);
      chk("flush_stall_valid", 64'(bus.wb_valid), 64'd0);
      chk("flush_stall_we", 64'(bus.wb_we), 64'd0);
      bus.wb_stall = 1'b0;

      // Flush clears a pending misaligned load
      bus.wb_flush = 1'b0;
      drive(1,1,5'd7,2'b01,3'b010,32'h1002,W,32'h0);
      tick(1,1);
      chk("mis_before_flush", 64'(bus.wb_misaligned), 64'd1);
      bus.wb_flush = 1'b1;
      tick(1,1);
      chk("mis_after_flush", 64'(bus.wb_misaligned), 64'd0);
      bus.wb_flush = 1'b0;

      // Reset in the middle of a stall discards the held instruction
      drive(1,1,5'd13,2'b00,3'b000,32'h5A,32'h0,32'h0);
      tick(1,0);
      bus.wb_stall = 1'b1;
      tick(1,0);
      chk("rststall_wd", 64'(bus.wb_wd), 64'h5A);
      rst = 1'b0;
      tick(1,0);
      chk_all_zero("rst_mid_stall");
      rst = 1'b1;
      bus.wb_stall = 1'b0;
      drive(0,0,5'd0,2'b00,3'b000,32'h0,32'h0,32'h0);
      tick(0,0);
      chk("rst_discard_cnt", bus.instret, 64'd0);

      // Counter wrap on a 2-bit instance: one retire per cycle
      bus2.mem_valid = 1'b1;
      bus2.mem_reg_write = 1'b1;
      bus2.mem_rd = 5'd1;
      bus2.mem_alu_result = 32'h1;
      for (int k = 1; k <= 5; k++) begin
         tick(0,0);
         chk($sformatf("wrap_edge%0d", k), 64'(bus2.instret), 64'((k - 1) % 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
